// File: rtl/fphub_pkg.sv
// Shared types and constants for the HUB-format divider front end.
package fphub_pkg;

    localparam int unsigned FP_M = 23;
    localparam int unsigned FP_E = 8;
    localparam int unsigned FP_W = FP_M + FP_E + 1;

    typedef logic [FP_W-1:0] fp_word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

    // Positive zero: sign clear, exponent and mantissa all zero.
    localparam logic     HUB_ZERO_SIGN = 1'b0;
    localparam fp_word_t HUB_POS_ZERO  = {HUB_ZERO_SIGN, {(FP_W-1){1'b0}}};

endpackage

// File: rtl/fphub_sync_fifo.sv
// Synchronous operand FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module fphub_sync_fifo
    import fphub_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata_c = mem[rptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/fphub_div_sequencer.sv
// Issues buffered operand pairs to the HUB SRT divider one at a time and returns tagged results.
// Optional watchdog enabled by defining FPHUB_DIV_SEQ_TIMEOUT_EN.
module fphub_div_sequencer
    import fphub_pkg::*;
#(
    parameter int unsigned M       = FP_M,
    parameter int unsigned E       = FP_E,
    parameter int unsigned N       = E + M,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = N + 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+E:0]     in_x,
    input  logic [M+E:0]     in_d,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_start,
    output logic [M+E:0]     div_x,
    output logic [M+E:0]     div_d,
    input  logic [M+E:0]     div_res,
    input  logic             div_finish,
    input  logic             div_computing,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+E:0]     out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned W  = M + E + 1;
    localparam int unsigned FW = 2 * W + TAG_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    seq_state_t       state;
    logic             push;
    logic             avail;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [FW-1:0]    head_c;
    logic [FW-1:0]    launch_word_c;
    logic [TAG_W-1:0] launch_tag;

    assign push     = in_valid && !fifo_full;
    assign in_ready = !fifo_full;
    // A write arriving this cycle counts as available so an idle block launches next cycle.
    assign avail         = (fifo_count != '0) || push;
    assign launch_word_c = fifo_empty ? {in_x, in_d, in_tag} : head_c;

    fphub_sync_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .push    (push),
        .pop     (div_start),
        .wdata   ({in_x, in_d, in_tag}),
        .rdata_c (head_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
    logic [WDOG_W-1:0] wdog;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= ST_IDLE;
            div_start  <= 1'b0;
            div_x      <= '0;
            div_d      <= '0;
            launch_tag <= '0;
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_tag    <= '0;
`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
            out_err    <= 1'b0;
            wdog       <= '0;
`endif
        end else begin
            div_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (avail && !div_computing) begin
                        state                         <= ST_LAUNCH;
                        div_start                     <= 1'b1;
                        {div_x, div_d, launch_tag}    <= launch_word_c;
                    end
                end
                ST_LAUNCH: begin
                    if (div_finish) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        out_res   <= div_res;
                        out_tag   <= launch_tag;
`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
                        out_err   <= 1'b0;
`endif
                    end else begin
                        state <= ST_WAIT;
`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
                        wdog  <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (div_finish) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        out_res   <= div_res;
                        out_tag   <= launch_tag;
`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
                        out_err   <= 1'b0;
                    end else if (wdog == WDOG_W'(TIMEOUT)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        out_res   <= W'(HUB_POS_ZERO);
                        out_tag   <= launch_tag;
                        out_err   <= 1'b1;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
`endif
                    end
                end
                ST_HOLD: begin
                    // Launch only after the result is taken, so at most one op is ever in flight.
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
                        out_err   <= 1'b0;
`endif
                        if (avail) begin
                            state                      <= ST_LAUNCH;
                            div_start                  <= 1'b1;
                            {div_x, div_d, launch_tag} <= launch_word_c;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fphub_div_sequencer.sv
// Self-checking bench: table vectors, directed corner sequences and a random run against an in-order scoreboard.
module tb_fphub_div_sequencer;

    localparam int unsigned M       = 23;
    localparam int unsigned E       = 8;
    localparam int unsigned N       = E + M;
    localparam int unsigned W       = M + E + 1;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = N + 8;

    logic             clk = 1'b0;
    logic             rst_l = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_x = '0;
    logic [W-1:0]     in_d = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             div_start;
    logic [W-1:0]     div_x;
    logic [W-1:0]     div_d;
    logic [W-1:0]     div_res;
    logic             div_finish;
    logic             div_computing;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_res;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Divider stand-in: zero-exponent dividends are "special" and finish in the start cycle,
    // everything else finishes N+1 cycles after the start.
    logic hold_busy = 1'b0;
    logic hang      = 1'b0;
    logic stray_fin = 1'b0;
    logic dv_busy;
    int   dv_rem;
    logic [W-1:0] dv_res_q;

    function automatic logic is_special(input logic [W-1:0] x);
        return x[30:23] == 8'h00;
    endfunction

    function automatic logic [W-1:0] div_fn(input logic [W-1:0] x, input logic [W-1:0] d);
        return is_special(x) ? {x[31] ^ d[31], 31'b0} : x + d;
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dv_busy  <= 1'b0;
            dv_rem   <= 0;
            dv_res_q <= '0;
        end else if (div_start && !is_special(div_x) && !hang) begin
            dv_busy  <= 1'b1;
            dv_rem   <= N;
            dv_res_q <= div_fn(div_x, div_d);
        end else if (dv_busy) begin
            if (dv_rem == 0) dv_busy <= 1'b0;
            else             dv_rem  <= dv_rem - 1;
        end
    end

    assign div_finish    = (div_start && is_special(div_x)) || (dv_busy && dv_rem == 0) || stray_fin;
    assign div_res       = (div_start && is_special(div_x)) ? div_fn(div_x, div_d) : dv_res_q;
    assign div_computing = dv_busy || hold_busy;

    fphub_div_sequencer #(
        .M(M), .E(E), .N(N), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_d          (in_d),
        .in_tag        (in_tag),
        .div_start     (div_start),
        .div_x         (div_x),
        .div_d         (div_d),
        .div_res       (div_res),
        .div_finish    (div_finish),
        .div_computing (div_computing),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_res       (out_res),
        .out_tag       (out_tag),
        .out_err       (out_err)
    );

    // Reference model: every accepted operand pair yields one result, in acceptance order.
    typedef struct packed {
        logic [W-1:0]     res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t             exp_q [$];
    logic [TAG_W-1:0] tag_log [$];
    int               starts_seen = 0;
    exp_t             sb_e;

    function automatic exp_t mk_exp(input logic [W-1:0] x, input logic [W-1:0] d,
                                    input logic [TAG_W-1:0] tag, input logic h);
        exp_t e;
        e.res = h ? '0 : div_fn(x, d);
        e.tag = tag;
        e.err = h;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_l) begin
            if (div_start) begin
                starts_seen++;
                check("start_while_valid", out_valid, 0);
            end
            if (in_valid && in_ready) exp_q.push_back(mk_exp(in_x, in_d, in_tag, hang));
            if (out_valid && out_ready) begin
                tag_log.push_back(out_tag);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_res", out_res, sb_e.res);
                    check("sb_tag", out_tag, sb_e.tag);
                    check("sb_err", out_err, sb_e.err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"},  in_ready,  1);
        check({pfx, "_div_start"}, div_start, 0);
        check({pfx, "_div_x"},     div_x,     0);
        check({pfx, "_div_d"},     div_d,     0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_out_res"},   out_res,   0);
        check({pfx, "_out_tag"},   out_tag,   0);
        check({pfx, "_out_err"},   out_err,   0);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [W-1:0]     x;
        logic [W-1:0]     d;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     res;
        int               lat;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        int cyc;
        int s0;
        logic [W-1:0]     r0;
        logic [TAG_W-1:0] t0;
        logic stable;
        logic cnt_ok;
        logic seen;

        vecs[0] = '{x: 32'h40400000, d: 32'h3F800001, tag: 4'd5,  res: 32'h7FC00001, lat: N + 3};
        vecs[1] = '{x: 32'h00000000, d: 32'h40000000, tag: 4'd2,  res: 32'h00000000, lat: 2};
        vecs[2] = '{x: 32'h80000000, d: 32'h40000000, tag: 4'd9,  res: 32'h80000000, lat: 2};
        vecs[3] = '{x: 32'h3F800000, d: 32'h3F800000, tag: 4'd15, res: 32'h7F000000, lat: N + 3};
        vecs[4] = '{x: 32'hC0000000, d: 32'h40A00000, tag: 4'd0,  res: 32'h00A00000, lat: N + 3};
        vecs[5] = '{x: 32'h00400000, d: 32'hBF800000, tag: 4'd7,  res: 32'h80000000, lat: 2};

        // Reset values
        tick(3);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_l = 1'b1;
        tick(2);

        // Single ops from an empty block, normal and special
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_x      = vecs[i].x;
            in_d      = vecs[i].d;
            in_tag    = vecs[i].tag;
            tick(1);
            in_valid  = 1'b0;
            s0        = starts_seen;
            @(negedge clk);
            check($sformatf("vec%0d_start", i), div_start, 1);
            check($sformatf("vec%0d_div_x", i), div_x, vecs[i].x);
            cyc = 1;
            while (!out_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
            check($sformatf("vec%0d_res", i), out_res, vecs[i].res);
            check($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
            check($sformatf("vec%0d_err", i), out_err, 0);
            check($sformatf("vec%0d_one_start", i), starts_seen - s0, 1);
            tick(1);
            @(negedge clk);
            check($sformatf("vec%0d_released", i), out_valid, 0);
            tick(1);
        end

        // Stray div_finish while idle is ignored
        stray_fin = 1'b1;
        tick(1);
        stray_fin = 1'b0;
        tick(3);
        @(negedge clk);
        check("stray_fin_idle", out_valid, 0);
        tick(1);

        // Backpressure: hold the first result for 50 cycles with two ops queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x = 32'h40000000; in_d = 32'h3F000000; in_tag = 4'd3; tick(1);
        in_x = 32'h41000000; in_d = 32'h3E000000; in_tag = 4'd4; tick(1);
        in_x = 32'h00000000; in_d = 32'h40000000; in_tag = 4'd5; tick(1);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_first_valid", out_valid, 1);
        r0 = out_res;
        t0 = out_tag;
        s0 = starts_seen;
        stable = 1'b1;
        cnt_ok = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_res !== r0 || out_tag !== t0 || out_valid !== 1'b1) stable = 1'b0;
            if (dut.u_fifo.count !== 3'd2) cnt_ok = 1'b0;
        end
        check("bp_res", r0, 32'h7F000000);
        check("bp_tag", t0, 3);
        check("bp_stable", stable, 1);
        check("bp_no_start", starts_seen - s0, 0);
        check("bp_count_held", cnt_ok, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("bp");
        tick(2);

        // FIFO fill while the divider reports busy
        hold_busy = 1'b1;
        tag_log.delete();
        s0 = starts_seen;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_x     = 32'h3F800000 + 32'(i);
            in_d     = 32'h40000000;
            in_tag   = 4'(i);
            @(negedge clk);
            check($sformatf("fill_ready_%0d", i), in_ready, 1);
            tick(1);
        end
        in_x   = 32'h3F800004;
        in_tag = 4'd4;
        @(negedge clk);
        check("fill_full", in_ready, 0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        check("fill_blocked", seen, 0);
        @(posedge clk); #1;
        hold_busy = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("fill_reopened", in_ready, 1);
        check("fill_pop_before_accept", starts_seen - s0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (tag_log.size() < 5 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("fill_result_count", tag_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < tag_log.size()) check($sformatf("fill_tag_order_%0d", i), tag_log[i], i);
        end
        tick(2);

        // Reset in cycle 10 of an operation
        in_valid = 1'b1;
        in_x = 32'h40400000; in_d = 32'h40000000; in_tag = 4'd11;
        tick(1);
        in_valid = 1'b0;
        tick(9);
        rst_l = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        tick(2);
        rst_l = 1'b1;
        s0   = starts_seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", seen, 0);
        check("midrst_no_start", starts_seen - s0, 0);
        tick(1);

        // Random traffic against the scoreboard
        for (int k = 0; k < 600; k++) begin
            in_valid = ($urandom_range(2) != 0);
            in_x     = $urandom;
            if ($urandom_range(3) == 0) in_x[30:23] = 8'h00;
            in_d     = $urandom;
            in_tag   = 4'($urandom);
            out_ready = ($urandom_range(9) < 7);
            tick(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand");
        tick(2);

`ifdef FPHUB_DIV_SEQ_TIMEOUT_EN
        // Watchdog: the divider never answers
        hang     = 1'b1;
        in_valid = 1'b1;
        in_x = 32'h40400000; in_d = 32'h40000000; in_tag = 4'd6;
        tick(1);
        in_valid = 1'b0;
        @(negedge clk);
        check("wd_start", div_start, 1);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("wd_latency", cyc, TIMEOUT + 3);
        check("wd_err", out_err, 1);
        check("wd_res", out_res, 0);
        check("wd_tag", out_tag, 6);
        tick(1);
        @(negedge clk);
        check("wd_err_cleared", out_err, 0);
        hang = 1'b0;
        tick(2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule
